// File: rtl/pc_lut_pkg.sv
// Shared definitions for the programmable branch-target lookup table:
// default geometry, sequencer state encoding and target assembly.
package pc_lut_pkg;

    localparam int LUT_D = 12;
    localparam int LUT_A = 6;
    localparam int LUT_B = 8;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LO     = 3'd1,
        HI     = 3'd2,
        COMMIT = 3'd3,
        CLEAR  = 3'd4
    } lut_state_t;

    // Joins a zero-extended high byte and the low byte into a max-width
    // target; callers size-cast the result down to their own D.
    function automatic logic [15:0] tgt_assemble(input logic [7:0] hi,
                                                 input logic [7:0] lo);
        return {hi, lo};
    endfunction

endpackage

// File: rtl/pc_lut_store.sv
// Target storage: DEPTH x D data words plus valid bits, one write port,
// one invalidate port and a combinational read port.
module pc_lut_store
    import pc_lut_pkg::*;
#(
    parameter int D = LUT_D,
    parameter int A = LUT_A
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         we,
    input  logic [A-1:0] waddr,
    input  logic [D-1:0] wdata,
    input  logic         inv,
    input  logic [A-1:0] iaddr,
    input  logic [A-1:0] raddr,
    output logic [D-1:0] rdata,
    output logic         rhit
);

    localparam int DEPTH = 1 << A;

    logic [D-1:0]     data_r [DEPTH];
    logic [DEPTH-1:0] valid_r;

    // Data words carry no reset; a stale word is hidden by its valid bit.
    always_ff @(posedge clk) begin
        if (we) begin
            data_r[waddr] <= wdata;
        end
    end

    // Valid bits: cleared on reset, set on write, cleared by the sweep.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_r <= {DEPTH{1'b0}};
        end else begin
            if (we) begin
                valid_r[waddr] <= 1'b1;
            end
            if (inv) begin
                valid_r[iaddr] <= 1'b0;
            end
        end
    end

    assign rhit = valid_r[raddr];

    // Read port masks invalid entries to zero.
    always_comb begin
        if (valid_r[raddr]) begin
            rdata = data_r[raddr];
        end else begin
            rdata = {D{1'b0}};
        end
    end

endmodule

// File: rtl/pc_lut_prog.sv
// Runtime-programmable branch-target LUT: byte-wide burst loader and
// invalidate sweep in front of a combinationally read target store.
module pc_lut_prog
    import pc_lut_pkg::*;
#(
    parameter int D = LUT_D,
    parameter int A = LUT_A,
    parameter int B = LUT_B
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [A-1:0] addr,
    output logic [D-1:0] target,
    output logic         hit,
    input  logic         ld_start,
    input  logic [A-1:0] ld_addr,
    input  logic         ld_valid,
    input  logic [B-1:0] ld_byte,
    input  logic         ld_last,
    output logic         ld_ready,
    input  logic         clr_start,
    output logic         busy
);

    lut_state_t   state_r;
    lut_state_t   state_nxt_s;
    logic [A-1:0] idx_r;
    logic [A-1:0] cnt_r;
    logic [7:0]   lo_r;
    logic [D-9:0] hi_r;
    logic         last_r;

    logic         ld_ready_s;
    logic         busy_s;
    logic         we_s;
    logic         inv_s;
    logic         accept_s;
    logic [D-1:0] wdata_s;

    assign accept_s = ld_valid && ld_ready_s;
    assign wdata_s  = D'(tgt_assemble(8'(hi_r), lo_r));

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic; a clear request outranks a load request.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (clr_start) begin
                    state_nxt_s = CLEAR;
                end else if (ld_start) begin
                    state_nxt_s = LO;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            LO: begin
                if (ld_valid) begin
                    state_nxt_s = HI;
                end else begin
                    state_nxt_s = LO;
                end
            end
            HI: begin
                if (ld_valid) begin
                    state_nxt_s = COMMIT;
                end else begin
                    state_nxt_s = HI;
                end
            end
            COMMIT: begin
                if (last_r) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = LO;
                end
            end
            CLEAR: begin
                if (cnt_r == {A{1'b1}}) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = CLEAR;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // Output decode: purely from the registered state.
    always_comb begin
        ld_ready_s = 1'b0;
        busy_s     = 1'b1;
        we_s       = 1'b0;
        inv_s      = 1'b0;
        case (state_r)
            IDLE: begin
                busy_s = 1'b0;
            end
            LO, HI: begin
                ld_ready_s = 1'b1;
            end
            COMMIT: begin
                we_s = 1'b1;
            end
            CLEAR: begin
                inv_s = 1'b1;
            end
            default: begin
                busy_s = 1'b0;
            end
        endcase
    end

    assign ld_ready = ld_ready_s;
    assign busy     = busy_s;

    // Entry index: loaded at burst start, advanced (with wrap) per commit.
    always_ff @(posedge clk) begin
        if (reset) begin
            idx_r <= {A{1'b0}};
        end else if (state_r == IDLE && !clr_start && ld_start) begin
            idx_r <= ld_addr;
        end else if (state_r == COMMIT && !last_r) begin
            idx_r <= idx_r + {{(A-1){1'b0}}, 1'b1};
        end
    end

    // Sweep counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_r <= {A{1'b0}};
        end else if (state_r == IDLE && clr_start) begin
            cnt_r <= {A{1'b0}};
        end else if (state_r == CLEAR) begin
            cnt_r <= cnt_r + {{(A-1){1'b0}}, 1'b1};
        end
    end

    // Byte capture; bits of the high byte above the target width are dropped.
    always_ff @(posedge clk) begin
        if (reset) begin
            lo_r   <= 8'h00;
            hi_r   <= {(D-8){1'b0}};
            last_r <= 1'b0;
        end else if (accept_s && state_r == LO) begin
            lo_r <= ld_byte[7:0];
        end else if (accept_s && state_r == HI) begin
            hi_r   <= ld_byte[D-9:0];
            last_r <= ld_last;
        end
    end

    pc_lut_store #(
        .D (D),
        .A (A)
    ) u_store (
        .clk   (clk),
        .reset (reset),
        .we    (we_s),
        .waddr (idx_r),
        .wdata (wdata_s),
        .inv   (inv_s),
        .iaddr (cnt_r),
        .raddr (addr),
        .rdata (target),
        .rhit  (hit)
    );

endmodule

// File: tb/tb_pc_lut_prog.sv
// Directed bench for pc_lut_prog: a transaction-level table model is compared
// against the DUT every cycle, plus hand-computed literal expectations.
module tb_pc_lut_prog;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [5:0]  addr = 6'd0;
    logic [11:0] target;
    logic        hit;
    logic        ld_start = 1'b0;
    logic [5:0]  ld_addr = 6'd0;
    logic        ld_valid = 1'b0;
    logic [7:0]  ld_byte = 8'h00;
    logic        ld_last = 1'b0;
    logic        ld_ready;
    logic        clr_start = 1'b0;
    logic        busy;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    pc_lut_prog dut (
        .clk       (clk),
        .reset     (reset),
        .addr      (addr),
        .target    (target),
        .hit       (hit),
        .ld_start  (ld_start),
        .ld_addr   (ld_addr),
        .ld_valid  (ld_valid),
        .ld_byte   (ld_byte),
        .ld_last   (ld_last),
        .ld_ready  (ld_ready),
        .clr_start (clr_start),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: the table contents plus where the loader/sweeper currently is.
    int  m_tbl [64];
    bit  m_valid [64];
    int  m_mode = 0;        // 0 idle, 1 want low byte, 2 want high byte, 3 writing, 4 sweeping
    int  m_idx = 0;
    int  m_sweep = 0;
    int  m_lo = 0;
    int  m_hi = 0;
    bit  m_last = 1'b0;

    always @(posedge clk) begin
        if (reset) begin
            m_mode = 0;
            m_idx = 0;
            m_sweep = 0;
            for (int i = 0; i < 64; i++) m_valid[i] = 1'b0;
        end else begin
            case (m_mode)
                0: begin
                    if (clr_start) begin
                        m_mode = 4;
                        m_sweep = 0;
                    end else if (ld_start) begin
                        m_mode = 1;
                        m_idx = int'(ld_addr);
                    end
                end
                1: if (ld_valid) begin m_lo = int'(ld_byte); m_mode = 2; end
                2: if (ld_valid) begin m_hi = int'(ld_byte) % 16; m_last = ld_last; m_mode = 3; end
                3: begin
                    m_tbl[m_idx] = m_hi * 256 + m_lo;
                    m_valid[m_idx] = 1'b1;
                    if (m_last) m_mode = 0;
                    else begin m_idx = (m_idx + 1) % 64; m_mode = 1; end
                end
                4: begin
                    m_valid[m_sweep] = 1'b0;
                    if (m_sweep == 63) m_mode = 0;
                    else m_sweep = m_sweep + 1;
                end
                default: m_mode = 0;
            endcase
        end
    end

    // Compare every cycle on the falling edge.
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("hit",      int'(hit),      int'(m_valid[addr]));
            chk("target",   int'(target),   m_valid[addr] ? m_tbl[addr] : 0);
            chk("busy",     int'(busy),     (m_mode != 0) ? 1 : 0);
            chk("ld_ready", int'(ld_ready), (m_mode == 1 || m_mode == 2) ? 1 : 0);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b, input logic l);
        ld_valid = 1'b1;
        ld_byte  = b;
        ld_last  = l;
        tick();
        ld_valid = 1'b0;
        ld_last  = 1'b0;
    endtask

    task automatic peek(input logic [5:0] a, input int exp_tgt, input int exp_hit, input string name);
        addr = a;
        #1;
        chk({name, "_target"}, int'(target), exp_tgt);
        chk({name, "_hit"}, int'(hit), exp_hit);
    endtask

    initial begin
        int n;
        tick();
        cmp_en = 1'b1;
        tick();
        reset = 1'b0;
        chk("rst_busy", int'(busy), 0);
        chk("rst_ready", int'(ld_ready), 0);
        for (int i = 0; i < 64; i++) begin
            addr = 6'(i);
            tick();
            chk("rst_sweep_hit", int'(hit), 0);
            chk("rst_sweep_tgt", int'(target), 0);
        end

        // Single entry at 5.
        ld_start = 1'b1; ld_addr = 6'd5; addr = 6'd5;
        tick();
        ld_start = 1'b0;
        chk("ld5_busy_lo", int'(busy), 1);
        send(8'h34, 1'b0);
        send(8'h02, 1'b1);
        chk("ld5_commit_busy", int'(busy), 1);
        peek(6'd5, 0, 0, "ld5_commit_old");
        tick();
        chk("ld5_busy_fall", int'(busy), 0);
        peek(6'd5, 12'h234, 1, "ld5");
        peek(6'd6, 0, 0, "ld6_empty");

        // Wrapping burst from 63, masked high byte, byte dropped during write.
        ld_start = 1'b1; ld_addr = 6'd63;
        tick();
        ld_start = 1'b0;
        send(8'h11, 1'b0);
        send(8'hF1, 1'b0);
        send(8'h99, 1'b0);
        send(8'h22, 1'b0);
        send(8'h02, 1'b1);
        tick();
        peek(6'd63, 12'h111, 1, "wrap63");
        peek(6'd0, 12'h222, 1, "wrap0");

        // Clear and load together: clear wins; load requests mid-sweep ignored.
        clr_start = 1'b1; ld_start = 1'b1; ld_addr = 6'd20;
        tick();
        clr_start = 1'b0;
        n = 0;
        while (busy && n < 200) begin
            n++;
            tick();
        end
        ld_start = 1'b0;
        chk("clr_cycles", n, 64);
        tick();
        chk("clr_idle_busy", int'(busy), 0);
        chk("clr_idle_ready", int'(ld_ready), 0);
        peek(6'd5, 0, 0, "clr5");
        peek(6'd63, 0, 0, "clr63");
        peek(6'd0, 0, 0, "clr0");

        // Reset while waiting for the high byte.
        ld_start = 1'b1; ld_addr = 6'd9;
        tick();
        ld_start = 1'b0;
        send(8'hAA, 1'b0);
        chk("mid_ready", int'(ld_ready), 1);
        reset = 1'b1; ld_valid = 1'b1; ld_byte = 8'h01; ld_last = 1'b1;
        tick();
        reset = 1'b0; ld_valid = 1'b0; ld_last = 1'b0;
        chk("mid_rst_busy", int'(busy), 0);
        peek(6'd9, 0, 0, "mid_rst9");
        tick();
        peek(6'd9, 0, 0, "mid_rst9_later");
        ld_start = 1'b1; ld_addr = 6'd9;
        tick();
        ld_start = 1'b0;
        send(8'h55, 1'b0);
        send(8'h01, 1'b1);
        tick();
        peek(6'd9, 12'h155, 1, "reload9");

        // Read during write at 7, then a dropped byte before entry 8.
        ld_start = 1'b1; ld_addr = 6'd7; addr = 6'd7;
        tick();
        ld_start = 1'b0;
        send(8'hAB, 1'b0);
        send(8'h00, 1'b0);
        chk("rdw_old_target", int'(target), 0);
        chk("rdw_old_hit", int'(hit), 0);
        send(8'h77, 1'b0);
        chk("rdw_new_target", int'(target), 12'h0AB);
        chk("rdw_new_hit", int'(hit), 1);
        send(8'hCD, 1'b0);
        send(8'h03, 1'b1);
        tick();
        peek(6'd8, 12'h3CD, 1, "after_drop8");
        peek(6'd7, 12'h0AB, 1, "keep7");
        tick();
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
